// File: rtl/l1inv_tx.sv
// L1 directory invalidation transmit: latches one lookup result and issues per-CPU
// CPX invalidate packets one at a time. Optional saturating ack counter under L1INV_STATS_EN.
module l1inv_tx #(
  parameter logic [3:0]  RTNTYPE = 4'b0011,
  parameter int unsigned ADDR_LO = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         vect_valid,
  input  logic [111:0] inval_vect0,
  input  logic [111:0] inval_vect1,
  input  logic [39:0]  address,
  output logic         busy,
  output logic         cpx_valid,
  output logic         cpx_cpu,
  output logic [144:0] cpx_packet,
  input  logic         cpx_ack,
  output logic         done,
  output logic         overrun
`ifdef L1INV_STATS_EN
  ,
  output logic [15:0]  inv_count
`endif
);

  localparam logic [111:0] CPU0_MASK = (112'hF) | (112'h7 << 32) | (112'hF << 56) | (112'h7 << 88);
  localparam logic [111:0] CPU1_MASK = (112'hF << 4) | (112'h7 << 35) | (112'hF << 60) | (112'h7 << 91);
  localparam logic [111:0] CPU0_HIT  = (112'h1) | (112'h1 << 32) | (112'h1 << 56) | (112'h1 << 88);
  localparam logic [111:0] CPU1_HIT  = (112'h1 << 4) | (112'h1 << 35) | (112'h1 << 60) | (112'h1 << 91);

  typedef enum logic [1:0] {IDLE, SCAN, SEND} state_t;

  state_t         state, state_next;
  logic [111:0]   v0_q, v1_q;
  logic [7:0]     addr_q;
  logic [3:0]     pending;
  logic [3:0]     need_in;
  logic [1:0]     slot, first_slot;
  logic           capture, finish, take_slot, accept;
  logic [111:0]   vec_sel, mask_sel;
  logic           unused_addr;

  assign unused_addr = ^address;

  // Slot index = {vector, cpu}; bit i of pending marks slot i still owed a packet.
  assign need_in = {|(inval_vect1 & CPU1_HIT), |(inval_vect1 & CPU0_HIT),
                    |(inval_vect0 & CPU1_HIT), |(inval_vect0 & CPU0_HIT)};

  always_comb begin
    first_slot = 2'd0;
    casez (pending)
      4'b???1: first_slot = 2'd0;
      4'b??10: first_slot = 2'd1;
      4'b?100: first_slot = 2'd2;
      4'b1000: first_slot = 2'd3;
      default: first_slot = 2'd0;
    endcase
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    finish     = 1'b0;
    take_slot  = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (vect_valid) begin
          capture    = 1'b1;
          state_next = SCAN;
        end
      end
      SCAN: begin
        if (|pending) begin
          take_slot  = 1'b1;
          state_next = SEND;
        end else begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      SEND: begin
        if (cpx_ack) begin
          accept     = 1'b1;
          state_next = SCAN;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v0_q    <= '0;
      v1_q    <= '0;
      addr_q  <= '0;
      pending <= '0;
      slot    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      done <= finish;
      if (capture) begin
        v0_q    <= inval_vect0;
        v1_q    <= inval_vect1;
        addr_q  <= address[ADDR_LO +: 8];
        pending <= need_in;
        busy    <= 1'b1;
      end
      if (finish)    busy <= 1'b0;
      if (take_slot) slot <= first_slot;
      if (accept)    pending[slot] <= 1'b0;
      if (vect_valid && busy) overrun <= 1'b1;
    end
  end

  assign vec_sel  = slot[1] ? v1_q : v0_q;
  assign mask_sel = slot[0] ? CPU1_MASK : CPU0_MASK;

  always_comb begin
    cpx_valid  = 1'b0;
    cpx_cpu    = 1'b0;
    cpx_packet = '0;
    if (state == SEND) begin
      cpx_valid  = 1'b1;
      cpx_cpu    = slot[0];
      cpx_packet = {1'b1, RTNTYPE, 20'h0, addr_q, vec_sel & mask_sel};
    end
  end

`ifdef L1INV_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               inv_count <= '0;
    else if (accept && (inv_count != '1))    inv_count <= inv_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_l1inv_tx.sv
// Scoreboard bench for l1inv_tx: directed latency/handshake cases plus randomized sequences
// checked against a group-range reference model.
module tb_l1inv_tx;

  logic         clk = 1'b0;
  logic         reset;
  logic         vect_valid;
  logic [111:0] inval_vect0, inval_vect1;
  logic [39:0]  address;
  logic         busy, cpx_valid, cpx_cpu, cpx_ack, done, overrun;
  logic [144:0] cpx_packet;
`ifdef L1INV_STATS_EN
  logic [15:0]  inv_count;
`endif

  l1inv_tx #(.RTNTYPE(4'b0011), .ADDR_LO(4)) dut (
    .clk(clk), .reset(reset), .vect_valid(vect_valid),
    .inval_vect0(inval_vect0), .inval_vect1(inval_vect1), .address(address),
    .busy(busy), .cpx_valid(cpx_valid), .cpx_cpu(cpx_cpu), .cpx_packet(cpx_packet),
    .cpx_ack(cpx_ack), .done(done), .overrun(overrun)
`ifdef L1INV_STATS_EN
    , .inv_count(inv_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed { logic cpu; logic [144:0] pkt; } exp_t;
  exp_t sbq[$];
  int errors = 0;
  int checks = 0;
  int exp_done = 0;
  int acked = 0;
  logic exp_overrun = 1'b0;

  // Group bit ranges per CPU; the low end of each group is its hit bit.
  localparam int LO [2][4] = '{'{0, 32, 56, 88}, '{4, 35, 60, 91}};
  localparam int HI [2][4] = '{'{3, 34, 59, 90}, '{7, 37, 63, 93}};

  task automatic chk(input string name, input logic [144:0] act, input logic [144:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_push(input logic [111:0] v0, input logic [111:0] v1,
                                     input logic [39:0] a);
    logic [111:0] vec, pl;
    logic hit;
    exp_t e;
    for (int v = 0; v < 2; v++) begin
      vec = (v == 0) ? v0 : v1;
      for (int c = 0; c < 2; c++) begin
        hit = 1'b0;
        pl  = '0;
        for (int g = 0; g < 4; g++) begin
          hit = hit | vec[LO[c][g]];
          for (int b = LO[c][g]; b <= HI[c][g]; b++) pl[b] = vec[b];
        end
        if (hit) begin
          e.cpu = c[0];
          e.pkt = {1'b1, 4'h3, 20'h0, a[11:4], pl};
          sbq.push_back(e);
        end
      end
    end
  endfunction

  function automatic logic [111:0] rand_vec();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    for (int c = 0; c < 2; c++)
      for (int g = 0; g < 4; g++) r[LO[c][g]] = ($urandom_range(0, 2) == 0);
    return r[111:0];
  endfunction

  task automatic issue(input logic [111:0] v0, input logic [111:0] v1, input logic [39:0] a);
    inval_vect0 = v0;
    inval_vect1 = v1;
    address     = a;
    vect_valid  = 1'b1;
    model_push(v0, v1, a);
    exp_done++;
    @(posedge clk); #1;
    vect_valid = 1'b0;
  endtask

  task automatic run_until_done(input bit rand_ack, input bit inject);
    bit got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      cpx_ack = rand_ack ? 1'($urandom_range(0, 1)) : 1'b1;
      if (inject && busy && $urandom_range(0, 7) == 0) begin
        inval_vect0 = rand_vec();
        inval_vect1 = rand_vec();
        address     = {$urandom, $urandom};
        vect_valid  = 1'b1;
        exp_overrun = 1'b1;
      end
      @(posedge clk); #1;
      vect_valid = 1'b0;
      if (done) got = 1;
      else      chk("busy_during_seq", busy, 1);
    end
    if (!got) chk("done_timeout", 0, 1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (cpx_valid && cpx_ack) begin
          if (sbq.size() == 0) chk("unexpected_packet", 1, 0);
          else begin
            e = sbq.pop_front();
            chk("cpx_cpu", cpx_cpu, e.cpu);
            chk("cpx_packet", cpx_packet, e.pkt);
            acked++;
          end
        end
        if (!cpx_valid) chk("idle_packet_zero", cpx_packet, 0);
        if (done) begin
          chk("done_expected", exp_done > 0, 1);
          if (exp_done > 0) exp_done--;
        end
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [144:0] held;
    logic [111:0] v;
    reset = 1'b1; vect_valid = 1'b0; cpx_ack = 1'b0;
    inval_vect0 = '0; inval_vect1 = '0; address = '0;
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_valid", cpx_valid, 0);
    chk("reset_packet", cpx_packet, 0);
    chk("reset_done", done, 0);
    chk("reset_overrun", overrun, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // single cpu0 packet, ack held high: valid at N+2, done at N+4
    cpx_ack = 1'b1;
    issue(112'h1, '0, 40'h12_3456_7890);
    chk("t1_scan_valid", cpx_valid, 0);
    chk("t1_scan_busy", busy, 1);
    @(posedge clk); #1;
    chk("t1_valid_n2", cpx_valid, 1);
    chk("t1_cpu", cpx_cpu, 0);
    chk("t1_packet", cpx_packet, {1'b1, 4'h3, 20'h0, 8'h89, 112'h1});
    @(posedge clk); #1;
    chk("t1_valid_n3", cpx_valid, 0);
    @(posedge clk); #1;
    chk("t1_done_n4", done, 1);
    chk("t1_busy_n4", busy, 0);

    // three packets: cpu0/bit56, cpu1/bit4, cpu1/bit91
    v = '0; v[4] = 1'b1; v[56] = 1'b1;
    inval_vect1 = '0;
    begin
      logic [111:0] w;
      w = '0; w[91] = 1'b1;
      issue(v, w, 40'hAB_CDEF_0123);
    end
    run_until_done(0, 0);

    // way-only bits: no packet, done at N+2
    issue(112'hC, '0, 40'h0);
    chk("t3_valid_n1", cpx_valid, 0);
    @(posedge clk); #1;
    chk("t3_done_n2", done, 1);
    chk("t3_valid_n2", cpx_valid, 0);

    // ack withheld for 5 cycles
    cpx_ack = 1'b0;
    issue(112'h11, '0, 40'h55_5555_5555);
    @(posedge clk); #1;
    chk("t4_valid", cpx_valid, 1);
    chk("t4_cpu0", cpx_cpu, 0);
    held = cpx_packet;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("t4_valid_hold", cpx_valid, 1);
      chk("t4_packet_hold", cpx_packet, held);
    end
    cpx_ack = 1'b1;
    @(posedge clk); #1;
    cpx_ack = 1'b0;
    chk("t4_gap", cpx_valid, 0);
    @(posedge clk); #1;
    chk("t4_next_valid", cpx_valid, 1);
    chk("t4_next_cpu", cpx_cpu, 1);
    run_until_done(0, 0);

    // second vect_valid during SEND is dropped and flags overrun
    cpx_ack = 1'b0;
    begin
      logic [111:0] w;
      w = '0; w[91] = 1'b1;
      issue(112'h1, w, 40'h01_0203_0405);
    end
    @(posedge clk); #1;
    inval_vect0 = '1; inval_vect1 = '1; vect_valid = 1'b1;
    @(posedge clk); #1;
    vect_valid = 1'b0;
    exp_overrun = 1'b1;
    chk("t5_overrun", overrun, 1);
    run_until_done(0, 0);
    chk("t5_overrun_sticky", overrun, 1);

    // reset mid-SEND clears everything with no done
    cpx_ack = 1'b0;
    issue(112'h10, '0, 40'h77_7777_7777);
    @(posedge clk); #1;
    chk("t6_in_send", cpx_valid, 1);
    reset = 1'b1;
    #1;
    chk("t6_rst_valid", cpx_valid, 0);
    chk("t6_rst_packet", cpx_packet, 0);
    chk("t6_rst_cpu", cpx_cpu, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_overrun", overrun, 0);
`ifdef L1INV_STATS_EN
    chk("t6_rst_count", inv_count, 0);
`endif
    sbq.delete();
    exp_done = 0;
    exp_overrun = 1'b0;
    acked = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("t6_after_busy", busy, 0);
    chk("t6_after_overrun", overrun, 0);

    // randomized sequences with random ack and overrun injection
    for (int n = 0; n < 80; n++) begin
      issue(rand_vec(), rand_vec(), {$urandom, $urandom});
      run_until_done(1, n >= 40);
    end
    chk("rand_overrun", overrun, exp_overrun);

    cpx_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sbq.size(), 0);
    chk("done_all_seen", exp_done, 0);
`ifdef L1INV_STATS_EN
    chk("inv_count", inv_count, (acked > 65535) ? 65535 : acked);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
